// File: rtl/opram_loader_pkg.sv
// Shared constants for the serial op RAM loader: loader/receiver state codes,
// default frame marker and UART framing. No timing or flow control of its own.
package opram_loader_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         UART_DATA_BITS    = 8;
  localparam int         UART_STOP_BITS    = 1;

endpackage

// File: rtl/opram_uart_rx.sv
// 8N1 UART receiver: rx_valid/frame_err pulse one clk after the mid-stop-bit sample.
// Latency about 2 sync clks + 9.5 bit times from the start edge; no backpressure.
module opram_uart_rx
  import opram_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta, rx_sync, rx_prev;
  logic [1:0]    rstate;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      rstate    <= R_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (rstate)
        R_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_sync) rstate <= R_START;
        end
        R_START: begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (cnt == HALF_M1) begin
            cnt    <= '0;
            rstate <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'(UART_DATA_BITS - 1)) rstate <= R_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == FULL_M1) begin
            cnt    <= '0;
            rstate <= R_IDLE;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/opram_loader.sv
// Loads a framed UART program image into op RAM from address 0; OPRAM_LOADER_CSUM_EN adds a checksum byte.
// write pulses 1 clk after each received data byte; no backpressure, the serial line sets the pace.
module opram_loader
  import opram_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         TIMEOUT_CLKS = 1000000,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       write,
  output logic [7:0] addr,
  output logic [7:0] writeop,
  output logic       cpu_hold,
  output logic       done,
  output logic       err
);

  localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  logic          rx_valid, frame_err;
  logic [7:0]    rx_data;
  logic [2:0]    state;
  logic [8:0]    remaining;
  logic [7:0]    idx;
  logic [TW-1:0] tmo;
  logic          in_frame, timed_out;
`ifdef OPRAM_LOADER_CSUM_EN
  logic [7:0]    sum;
`endif

  opram_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .frame_err (frame_err)
  );

  assign in_frame  = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
  assign timed_out = in_frame && !rx_valid && (tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      idx       <= '0;
      tmo       <= '0;
      write     <= 1'b0;
      addr      <= '0;
      writeop   <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef OPRAM_LOADER_CSUM_EN
      sum       <= '0;
`endif
    end else begin
      write <= 1'b0;
      if (!in_frame || rx_valid) tmo <= '0;
      else if (tmo != TMO_LAST)  tmo <= tmo + 1'b1;

      // Abort keeps cpu_hold high so the CPU never runs a partial image.
      if (in_frame && (frame_err || timed_out)) begin
        err   <= 1'b1;
        done  <= 1'b0;
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
              cpu_hold <= 1'b1;
              done     <= 1'b0;
              err      <= 1'b0;
              state    <= ST_LEN;
`ifdef OPRAM_LOADER_CSUM_EN
              sum      <= '0;
`endif
            end
          end
          ST_LEN: begin
            if (rx_valid) begin
              remaining <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
              idx       <= '0;
              state     <= ST_DATA;
`ifdef OPRAM_LOADER_CSUM_EN
              sum       <= sum + rx_data;
`endif
            end
          end
          ST_DATA: begin
            if (rx_valid) begin
              write     <= 1'b1;
              writeop   <= rx_data;
              addr      <= idx;
              idx       <= idx + 1'b1;
              remaining <= remaining - 1'b1;
`ifdef OPRAM_LOADER_CSUM_EN
              sum       <= sum + rx_data;
              if (remaining == 9'd1) state <= ST_CSUM;
`else
              if (remaining == 9'd1) state <= ST_DONE;
`endif
            end
          end
`ifdef OPRAM_LOADER_CSUM_EN
          ST_CSUM: begin
            if (rx_valid) begin
              if (rx_data == sum) begin
                state <= ST_DONE;
              end else begin
                err   <= 1'b1;
                done  <= 1'b0;
                state <= ST_IDLE;
              end
            end
          end
`endif
          ST_DONE: begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            state    <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/opram_loader.md
Name: opram_loader

Overview:
- Serial program loader upstream of the opram write port (write/addr/writeop) of the GCore CPU.
- Receives a framed program image over a UART RX line and writes it byte-by-byte into op RAM starting at address 0.
- Holds the CPU (cpu_hold) while loading so the pc and clk_gen restart cleanly on the new image.

Parameters:
- CLKS_PER_BIT, 434, system clocks per UART bit (50 MHz / 115200); minimum 8.
- TIMEOUT_CLKS, 1000000, idle clocks allowed between bytes inside a frame before abort.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx  in  1  UART serial input; asynchronous, idle high
- write  out  1  opram write strobe, one-cycle pulse per data byte
- addr  out  8  opram write address
- writeop  out  8  opram write data
- cpu_hold  out  1  high while a frame is in progress or after a failed load
- done  out  1  level; last frame loaded successfully
- err  out  1  level, sticky; last frame aborted

Behaviour:
- Reset values: write=0, addr=0, writeop=0, cpu_hold=0, done=0, err=0, FSM=IDLE, RX=R_IDLE. Reset mid-frame discards the frame with no further writes.
- RX front end:
  - 2-flop synchronizer on rx.
  - Falling edge in R_IDLE starts a bit counter. The line is re-sampled at CLKS_PER_BIT/2; if it is high, return to R_IDLE (glitch).
  - 8 data bits are then sampled LSB first, each CLKS_PER_BIT apart at mid-bit, followed by a stop-bit sample.
  - Stop=1: rx_valid pulses 1 cycle with rx_data. Stop=0: frame_err pulses 1 cycle and the byte is discarded.
- Loader FSM states: IDLE, LEN, DATA, CSUM, DONE.
  - IDLE: bytes other than SYNC_BYTE are ignored. On SYNC_BYTE: cpu_hold=1, done=0, err=0, sum=0 → LEN.
  - LEN: capture count = byte; a value of 0 means 256. sum += byte → DATA; addr is set to 0 for the first write.
  - DATA: on each byte, the next cycle drives write=1, writeop=byte, addr=current index, and sum += byte.
    - The index increments after each write; addr wraps 255→0 only at the end of a 256-byte frame.
    - After the final byte → CSUM (macro defined) or DONE.
  - DONE: done=1, cpu_hold=0 → IDLE.
- Write latency: write is asserted exactly 1 clk after rx_valid; at most one write per received byte. addr and writeop hold their values after the write pulse.
- Abort conditions, checked in LEN/DATA/CSUM:
  - frame_err, or TIMEOUT_CLKS cycles with no completed byte → err=1, cpu_hold stays 1, FSM → IDLE.
  - Already-written bytes are not rolled back.
  - err and cpu_hold clear only on the next SYNC_BYTE or on rst.
- SYNC_BYTE received inside LEN/DATA/CSUM is treated as ordinary data; frames do not restart mid-frame.
- The timeout counter resets on every rx_valid and saturates; it is inactive in IDLE.

Optional Feature:
- Macro: OPRAM_LOADER_CSUM_EN.
- Defined: after the last data byte, the FSM enters CSUM and expects one byte equal to the 8-bit sum mod 256 of the LEN byte and all data bytes.
  - Match → DONE.
  - Mismatch → err=1, done=0, cpu_hold stays 1, FSM → IDLE.
- Undefined: the CSUM state and the sum register are absent; the last data byte leads directly to DONE.

Decomposition:
- Shared package: loader state enum (IDLE, LEN, DATA, CSUM, DONE), default SYNC_BYTE, UART frame constants (data bits = 8, stop bits = 1).
- One sub-module: opram_uart_rx (synchronizer, bit timing, rx_valid/rx_data/frame_err). The loader FSM stays in opram_loader.

Test Plan (CLKS_PER_BIT=16, TIMEOUT_CLKS=2000):
- Send A5, 03, 11, 22, 33, csum 69 → writes (0,11), (1,22), (2,33), each 1 clk after the byte; done=1, cpu_hold=0, err=0.
- Send FF, 00 then A5, 01, 7E, csum 7F → leading bytes ignored; single write (0,7E); done=1.
- Send A5, 02, 10 then idle 2000 clks → err=1, cpu_hold=1, exactly one write; a later good frame clears err.
- Send A5, 02 then a byte with stop bit=0 → err=1, no writes; IDLE reached.
- Send A5, 00, then 256 bytes 0..255 → 256 writes with addr=0..255; with the macro defined, a wrong csum (00) gives err=1, done=0.
- Assert rst in the middle of the DATA phase → all outputs 0 on the next clk; no write pulse follows.
